// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction fetch stage.
// Widths here are the 32-bit defaults; users cast them to their own widths.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] BUBBLE       = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'h0000_0004;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the instruction-memory, control-flow and decode-side signals of the fetch stage.
// The master modport is the fetch stage itself; slave is the surrounding pipeline/memory.
interface fetch_stage_if #(
    parameter int unsigned W_AA_INSTR = 32,
    parameter int unsigned W_AD_INSTR = 32
);

    logic [W_AA_INSTR-1:0] IMO_AA_addr;
    logic                  IMO_PV_req;
    logic                  IMI_PV_gnt;
    logic                  IMI_PV_rvalid;
    logic [W_AD_INSTR-1:0] IMI_AD_data;
    logic                  CFI_PC_redirect;
    logic [W_AA_INSTR-1:0] CFI_AA_target;
    logic                  CFI_PC_stall;
    logic [W_AD_INSTR-1:0] DFO_AD_instr;
    logic [W_AA_INSTR-1:0] DFO_AA_pc;
    logic [W_AA_INSTR-1:0] DFO_AA_spec;
    logic                  CFO_PC_clear;

    modport master (
        output IMO_AA_addr, IMO_PV_req,
        input  IMI_PV_gnt, IMI_PV_rvalid, IMI_AD_data,
        input  CFI_PC_redirect, CFI_AA_target, CFI_PC_stall,
        output DFO_AD_instr, DFO_AA_pc, DFO_AA_spec, CFO_PC_clear
    );

    modport slave (
        input  IMO_AA_addr, IMO_PV_req,
        output IMI_PV_gnt, IMI_PV_rvalid, IMI_AD_data,
        output CFI_PC_redirect, CFI_AA_target, CFI_PC_stall,
        input  DFO_AD_instr, DFO_AA_pc, DFO_AA_spec, CFO_PC_clear
    );

endinterface

// File: rtl/fetch_stage_checker.sv
// Protocol and bookkeeping assertions for the fetch stage; no logic, simulation only.
module fetch_stage_checker #(
    parameter int unsigned CW = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          rvalid,
    input logic [CW-1:0] out_cnt,
    input logic [CW-1:0] drop_cnt,
    input logic [CW-1:0] pcq_cnt
);

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        rvalid |-> (out_cnt != {CW{1'b0}}));

    a_drop_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        drop_cnt <= out_cnt);

    // Every in-flight request that will be kept owns exactly one PC FIFO slot.
    a_pc_fifo_tracks: assert property (@(posedge clk) disable iff (!rst_n)
        pcq_cnt == (out_cnt - drop_cnt));

endmodule

// File: rtl/fetch_stage_fetch_queue.sv
// Small synchronous FIFO with a flush input; head_data is the raw head slot and is
// only meaningful while count is non-zero. DEPTH must be a power of two.
module fetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && (count_r != CW'(DEPTH));
    assign do_pop_s  = pop && (count_r != {CW{1'b0}});
    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; flush empties without touching the storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, in-order memory requests, a fetch queue of
// {instr, pc, pc+4} entries, and redirect handling that discards stale responses.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned           W_AA_INSTR = 32,
    parameter int unsigned           W_AD_INSTR = 32,
    parameter logic [W_AA_INSTR-1:0] RESET_PC   = W_AA_INSTR'(RESET_PC_DEF),
    parameter int unsigned           FQ_DEPTH   = 4
) (
    input logic           clk,
    input logic           rst_n,
    fetch_stage_if.master bus
);

    localparam int unsigned           CW        = $clog2(FQ_DEPTH + 1);
    localparam int unsigned           EW        = W_AD_INSTR + 2 * W_AA_INSTR;
    localparam logic [W_AA_INSTR-1:0] INC       = W_AA_INSTR'(PC_INC);
    localparam logic [CW:0]           DEPTH_EXT = (CW + 1)'(FQ_DEPTH);

    logic [W_AA_INSTR-1:0] pc_r;
    logic [CW-1:0]         out_r;
    logic [CW-1:0]         drop_r;
    logic [CW-1:0]         occ_s;
    logic [CW-1:0]         pcq_cnt_s;
    logic [W_AA_INSTR-1:0] pcq_head_s;
    logic [EW-1:0]         iq_head_s;
    logic [EW-1:0]         iq_push_data_s;
    logic [CW:0]           pending_s;
    logic                  empty_s;
    logic                  req_s;
    logic                  grant_s;
    logic                  rsp_s;
    logic                  drop_hit_s;
    logic                  keep_s;
    logic                  pop_s;

    assign pending_s  = {1'b0, occ_s} + {1'b0, out_r};
    assign empty_s    = (occ_s == {CW{1'b0}});
    // Holding back requests whenever occ+out reaches the depth reserves a queue slot for every word in flight.
    assign req_s      = !bus.CFI_PC_redirect && (pending_s < DEPTH_EXT);
    assign grant_s    = req_s && bus.IMI_PV_gnt;
    assign rsp_s      = bus.IMI_PV_rvalid && (out_r != {CW{1'b0}});
    assign drop_hit_s = rsp_s && (drop_r != {CW{1'b0}});
    assign keep_s     = rsp_s && (drop_r == {CW{1'b0}}) && !bus.CFI_PC_redirect;
    assign pop_s      = !bus.CFI_PC_stall && !empty_s && !bus.CFI_PC_redirect;

    assign iq_push_data_s = {bus.IMI_AD_data, pcq_head_s, pcq_head_s + INC};

    assign bus.IMO_AA_addr  = pc_r;
    assign bus.IMO_PV_req   = req_s;
    assign bus.CFO_PC_clear = empty_s || bus.CFI_PC_redirect;
    assign bus.DFO_AD_instr = empty_s ? W_AD_INSTR'(BUBBLE) : iq_head_s[EW-1 -: W_AD_INSTR];
    assign bus.DFO_AA_pc    = empty_s ? W_AA_INSTR'(BUBBLE) : iq_head_s[2*W_AA_INSTR-1 -: W_AA_INSTR];
    assign bus.DFO_AA_spec  = empty_s ? W_AA_INSTR'(BUBBLE) : iq_head_s[W_AA_INSTR-1:0];

    // Fetch PC, in-flight count and count of stale responses still to be discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r   <= RESET_PC;
            out_r  <= {CW{1'b0}};
            drop_r <= {CW{1'b0}};
        end else if (bus.CFI_PC_redirect) begin
            pc_r   <= bus.CFI_AA_target;
            out_r  <= out_r - CW'(rsp_s);
            drop_r <= out_r - CW'(rsp_s);
        end else begin
            if (grant_s) begin
                pc_r <= pc_r + INC;
            end
            out_r  <= out_r + CW'(grant_s) - CW'(rsp_s);
            drop_r <= drop_r - CW'(drop_hit_s);
        end
    end

    // Stale entries were flushed at redirect, so only kept responses consume a PC slot.
    fetch_queue #(
        .WIDTH (W_AA_INSTR),
        .DEPTH (FQ_DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.CFI_PC_redirect),
        .push      (grant_s),
        .push_data (pc_r),
        .pop       (keep_s),
        .head_data (pcq_head_s),
        .count     (pcq_cnt_s)
    );

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (FQ_DEPTH)
    ) u_instr_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.CFI_PC_redirect),
        .push      (keep_s),
        .push_data (iq_push_data_s),
        .pop       (pop_s),
        .head_data (iq_head_s),
        .count     (occ_s)
    );

    fetch_stage_checker #(
        .CW (CW)
    ) u_checker (
        .clk      (clk),
        .rst_n    (rst_n),
        .rvalid   (bus.IMI_PV_rvalid),
        .out_cnt  (out_r),
        .drop_cnt (drop_r),
        .pcq_cnt  (pcq_cnt_s)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage: an in-order memory model with per-request latency,
// a reference queue of expected decode entries, and a monitor comparing at decode capture.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        int          epoch;
    } mem_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] spec;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fetch_stage_if #(.W_AA_INSTR(32), .W_AD_INSTR(32)) bus ();

    fetch_stage #(
        .W_AA_INSTR (32),
        .W_AD_INSTR (32),
        .RESET_PC   (RST_PC),
        .FQ_DEPTH   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    mem_t        pending[$];
    exp_t        exp_q[$];
    logic [31:0] model_pc = RST_PC;
    int          epoch = 0;
    int          cyc = 0;
    int          max_pend = 0;
    int          gnt_pct = 100;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          data_is_addr = 1'b1;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // One clock cycle: drive inputs, check request-side outputs, then advance the model.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
        logic g, rv, exp_req, exp_clr;
        mem_t h;
        @(negedge clk);
        g  = ($urandom_range(99) < gnt_pct);
        rv = (pending.size() != 0) && (pending[0].due <= cyc);
        bus.IMI_PV_gnt      = g;
        bus.IMI_PV_rvalid   = rv;
        bus.IMI_AD_data     = rv ? pending[0].data : $urandom;
        bus.CFI_PC_stall    = st;
        bus.CFI_PC_redirect = rd;
        bus.CFI_AA_target   = tgt;
        #2;
        exp_req = !rd && ((exp_q.size() + pending.size()) < 4);
        exp_clr = rd || (exp_q.size() == 0);
        chk("req", {31'b0, bus.IMO_PV_req}, {31'b0, exp_req});
        chk("addr", bus.IMO_AA_addr, model_pc);
        chk("clear", {31'b0, bus.CFO_PC_clear}, {31'b0, exp_clr});
        #2;
        if (rv) begin
            h = pending.pop_front();
            if (!rd && h.epoch == epoch) exp_q.push_back('{h.data, h.addr, h.addr + 32'd4});
        end
        if (rd) begin
            epoch++;
            exp_q.delete();
            model_pc = tgt;
        end else if (exp_req && g) begin
            pending.push_back('{model_pc, data_is_addr ? model_pc : 32'($urandom),
                                cyc + $urandom_range(lat_hi, lat_lo), epoch});
            model_pc = model_pc + 32'd4;
        end
        if (pending.size() > max_pend) max_pend = pending.size();
        cyc++;
    endtask

    // Asynchronous reset pulse; stray responses are driven while reset is held.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus.CFI_PC_redirect = 1'b0;
        bus.CFI_PC_stall    = 1'b0;
        #1;
        chk("rst_clear", {31'b0, bus.CFO_PC_clear}, 32'd1);
        chk("rst_instr", bus.DFO_AD_instr, 32'd0);
        chk("rst_pc", bus.DFO_AA_pc, 32'd0);
        chk("rst_spec", bus.DFO_AA_spec, 32'd0);
        chk("rst_req", {31'b0, bus.IMO_PV_req}, 32'd1);
        chk("rst_addr", bus.IMO_AA_addr, RST_PC);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.IMI_PV_rvalid = 1'b1;
            bus.IMI_PV_gnt    = 1'b1;
            bus.IMI_AD_data   = $urandom;
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.IMI_PV_rvalid = 1'b0;
        bus.IMI_PV_gnt    = 1'b0;
        pending.delete();
        exp_q.delete();
        model_pc = RST_PC;
        epoch++;
    endtask

    // Monitor: compares the head whenever decode captures it, and bubbles when empty.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                if (!bus.CFI_PC_stall && !bus.CFO_PC_clear) begin
                    chk("head_available", {31'b0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("dfo_instr", bus.DFO_AD_instr, e.instr);
                        chk("dfo_pc", bus.DFO_AA_pc, e.pc);
                        chk("dfo_spec", bus.DFO_AA_spec, e.spec);
                    end
                end else if (bus.CFO_PC_clear && !bus.CFI_PC_redirect) begin
                    chk("bubble_instr", bus.DFO_AD_instr, 32'd0);
                    chk("bubble_pc", bus.DFO_AA_pc, 32'd0);
                    chk("bubble_spec", bus.DFO_AA_spec, 32'd0);
                end
            end
        end
    end

    initial begin
        int  nclr;
        bit  found;
        bus.IMI_PV_gnt      = 1'b0;
        bus.IMI_PV_rvalid   = 1'b0;
        bus.IMI_AD_data     = 32'd0;
        bus.CFI_PC_redirect = 1'b0;
        bus.CFI_AA_target   = 32'd0;
        bus.CFI_PC_stall    = 1'b0;
        do_reset();

        // Single-cycle memory, data = address, no stall.
        nclr = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 32'd0);
            nclr += int'(bus.CFO_PC_clear);
        end
        chk("fill_clear_cycles", nclr, 32'd2);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 32'd0);

        // Stall while head is 0x10: queue fills and requests stop.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 32'd0);
            chk("stall_head", bus.DFO_AA_pc, 32'h10);
        end
        chk("stall_req_off", {31'b0, bus.IMO_PV_req}, 32'd0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 32'd0);

        // Three-cycle latency: in-flight limit.
        lat_lo = 3; lat_hi = 3; data_is_addr = 1'b0;
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 32'd0);
        chk("max_inflight_le4", {31'b0, max_pend <= 4}, 32'd1);

        // Redirect to 0x200 with three requests in flight.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0);
        chk("inflight_before_redirect", pending.size(), 32'd3);
        cycle(1'b0, 1'b1, 32'h200);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle(1'b0, 1'b0, 32'd0);
            if (!bus.CFO_PC_clear && bus.DFO_AA_pc == 32'h200) found = 1'b1;
        end
        chk("redirect_head_seen", {31'b0, found}, 32'd1);
        chk("redirect_head_spec", bus.DFO_AA_spec, 32'h204);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'd0);

        // Redirect, response and stall in the same cycle.
        do_reset();
        lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 32'h80);
        cycle(1'b1, 1'b0, 32'd0);
        chk("redirect_stall_empty", {31'b0, bus.CFO_PC_clear}, 32'd1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 32'd0);

        // PC wrap at the top of the address space.
        lat_lo = 1; lat_hi = 1;
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        chk("pc_wrap", bus.IMO_AA_addr, 32'h0000_0000);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'd0);

        // Random traffic with a reset pulse in the middle of a burst.
        gnt_pct = 70; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 1500; i++) begin
            logic        rd;
            logic [31:0] tgt;
            if (i == 750) do_reset();
            rd  = ($urandom_range(99) < 4);
            tgt = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            cycle($urandom_range(99) < 25, rd, tgt);
        end
        chk("max_inflight_final", {31'b0, max_pend <= 4}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
